pipe_debug_ctrl: RTL and testbench

Run-control sequencer for the five-stage pipeline. It holds a small table of PC breakpoints, compares it against the instruction sitting in ID, and asserts `freeze_id` to stop issue: IF/ID holds and ID/EX receives bubbles. It turns debounced front-panel continue/step buttons into resume and single/multi-step sequences. It replaces the hard-wired single-address breakpoint and asynchronous continue latch in the decode stage.

---
 rtl/pipe_debug_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_pipe_debug_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pipe_debug_ctrl.sv
// Run-control sequencer for the five-stage pipeline: PC breakpoint table, button
// conditioning, and the RUN/HALT/STEP/RESUME issue-freeze state machine.

module pipe_debug_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [1:0]    sync_q;
  logic          level_q, level_d, level_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronizer, debounced level, stability counter and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b00;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= {sync_q[0], btn_i};
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign pulse_o = level_q & ~level_prev_q;
endmodule

module pipe_debug_ctrl #(
  parameter int NUM_BP          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_WIDTH      = 8,
  localparam int IW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           id_pc,
  input  logic                  id_valid,
  input  logic                  id_advance,
  input  logic                  bp_wr_en,
  input  logic [IW-1:0]         bp_wr_idx,
  input  logic [31:0]           bp_wr_addr,
  input  logic                  bp_wr_arm,
  input  logic                  btn_continue,
  input  logic                  btn_step,
  input  logic [STEP_WIDTH-1:0] step_count,
  input  logic                  halt_req,
  output logic                  freeze_id,
  output logic                  halted,
  output logic [1:0]            halt_cause,
  output logic [IW-1:0]         hit_idx,
  output logic [1:0]            state_o
);
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_STEP   = 2'd2,
    ST_RESUME = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_BP   = 2'd1;
  localparam logic [1:0] CAUSE_STEP = 2'd2;
  localparam logic [1:0] CAUSE_EXT  = 2'd3;

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
  logic [1:0]            cause_q, cause_d;
  logic [IW-1:0]         hit_idx_q, hit_idx_d;
  logic                  halted_q;
  logic [1:0]            state_o_q;
  logic [29:0]           bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0]     bp_arm_q;
  logic [NUM_BP-1:0]     bp_match_s;
  logic [IW-1:0]         bp_idx_s;
  logic                  bp_hit_s, freeze_s, cont_p, step_p, unused_s;

  pipe_debug_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cont (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_continue), .pulse_o(cont_p)
  );
  pipe_debug_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_step), .pulse_o(step_p)
  );

  // Breakpoint table; slot index comparison drops out-of-range writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr_q[i] <= 30'd0;
        bp_arm_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_wr_en && (bp_wr_idx == IW'(i))) begin
          bp_addr_q[i] <= bp_wr_addr[31:2];
          bp_arm_q[i]  <= bp_wr_arm;
        end
      end
    end
  end

  // Word-address compare; descending scan leaves the lowest matching slot
  always_comb begin
    bp_idx_s = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      bp_match_s[i] = bp_arm_q[i] & (bp_addr_q[i] == id_pc[31:2]);
      bp_idx_s      = bp_match_s[i] ? IW'(i) : bp_idx_s;
    end
  end

  assign bp_hit_s = id_valid & (|bp_match_s);
  assign unused_s = ^{id_pc[1:0], bp_wr_addr[1:0]};

  // Run-control next state, halt bookkeeping and issue freeze
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cause_d     = cause_q;
    hit_idx_d   = hit_idx_q;
    freeze_s    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bp_hit_s) begin
          state_d   = ST_HALT;
          cause_d   = CAUSE_BP;
          hit_idx_d = bp_idx_s;
          freeze_s  = 1'b1;
        end else if (halt_req) begin
          state_d  = ST_HALT;
          cause_d  = CAUSE_EXT;
          freeze_s = 1'b1;
        end else begin
          freeze_s = 1'b0;
        end
      end
      ST_HALT: begin
        freeze_s = 1'b1;
        if (cont_p) begin
          state_d = ST_RESUME;
        end else if (step_p) begin
          state_d     = ST_STEP;
          remaining_d = (step_count == '0) ? STEP_WIDTH'(1) : step_count;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_RESUME: begin
        // Breakpoints are masked here so the halted instruction can leave ID
        if (halt_req) begin
          state_d  = ST_HALT;
          cause_d  = CAUSE_EXT;
          freeze_s = 1'b1;
        end else if (id_advance) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_RESUME;
        end
      end
      ST_STEP: begin
        if (id_advance && (remaining_q == STEP_WIDTH'(1))) begin
          state_d     = ST_HALT;
          cause_d     = CAUSE_STEP;
          remaining_d = '0;
        end else if (id_advance) begin
          remaining_d = remaining_q - STEP_WIDTH'(1);
        end else begin
          remaining_d = remaining_q;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, step budget and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      remaining_q <= '0;
      cause_q     <= 2'd0;
      hit_idx_q   <= '0;
      halted_q    <= 1'b0;
      state_o_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cause_q     <= cause_d;
      hit_idx_q   <= hit_idx_d;
      halted_q    <= (state_d == ST_HALT);
      state_o_q   <= state_d;
    end
  end

  assign freeze_id  = freeze_s;
  assign halted     = halted_q;
  assign halt_cause = cause_q;
  assign hit_idx    = hit_idx_q;
  assign state_o    = state_o_q;
endmodule

// File: tb/tb_pipe_debug_ctrl.sv
// Directed bench for pipe_debug_ctrl: expected status vectors go through a
// scoreboard queue and are checked half a cycle after each rising edge.
module tb_pipe_debug_ctrl;
  localparam int NUM_BP = 4;
  localparam int DB     = 4;
  localparam int SW     = 8;
  localparam int IW     = 2;
  localparam logic [1:0] S_RUN = 2'd0, S_HALT = 2'd1, S_STEP = 2'd2, S_RESUME = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   id_pc;
  logic          id_valid, id_advance;
  logic          bp_wr_en;
  logic [IW-1:0] bp_wr_idx;
  logic [31:0]   bp_wr_addr;
  logic          bp_wr_arm;
  logic          btn_continue, btn_step;
  logic [SW-1:0] step_count;
  logic          halt_req;
  logic          freeze_id, halted;
  logic [1:0]    halt_cause;
  logic [IW-1:0] hit_idx;
  logic [1:0]    state_o;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;

  pipe_debug_ctrl #(.NUM_BP(NUM_BP), .DEBOUNCE_CYCLES(DB), .STEP_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_valid(id_valid), .id_advance(id_advance),
    .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr), .bp_wr_arm(bp_wr_arm),
    .btn_continue(btn_continue), .btn_step(btn_step), .step_count(step_count),
    .halt_req(halt_req), .freeze_id(freeze_id), .halted(halted), .halt_cause(halt_cause),
    .hit_idx(hit_idx), .state_o(state_o)
  );

  // Expected {freeze, halted, cause, hit_idx, state}; halted follows from the state.
  task automatic chk(input string tag, input logic fz, input logic [1:0] st,
                     input logic [1:0] cause, input logic [IW-1:0] hit);
    logic [7:0] exp_v, obs_v;
    string      t;
    exp_q.push_back({fz, (st == S_HALT), cause, hit, st});
    tag_q.push_back(tag);
    #1;
    obs_v = {freeze_id, halted, halt_cause, hit_idx, state_o};
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    total_cnt++;
    assert (obs_v === exp_v) pass_cnt++;
    else $error("FAIL %s: observed fz/hlt/cause/hit/st=%b expected %b", t, obs_v, exp_v);
  endtask

  task automatic cyc(input string tag, input logic fz, input logic [1:0] st,
                     input logic [1:0] cause, input logic [IW-1:0] hit);
    chk(tag, fz, st, cause, hit);
    @(negedge clk);
  endtask

  task automatic hold(input int n, input string tag, input logic fz, input logic [1:0] st,
                      input logic [1:0] cause, input logic [IW-1:0] hit);
    for (int i = 0; i < n; i++) cyc(tag, fz, st, cause, hit);
  endtask

  initial begin
    rst_n = 1'b0; id_pc = 32'd0; id_valid = 1'b0; id_advance = 1'b0;
    bp_wr_en = 1'b0; bp_wr_idx = 2'd0; bp_wr_addr = 32'd0; bp_wr_arm = 1'b0;
    btn_continue = 1'b0; btn_step = 1'b0; step_count = 8'd0; halt_req = 1'b0;
    @(negedge clk);
    cyc("reset", 1'b0, S_RUN, 2'd0, 2'd0);

    // Slot write with PC 48 in ID: compare sees the old (disarmed) slot, so halt_req decides
    rst_n = 1'b1; bp_wr_en = 1'b1; bp_wr_idx = 2'd2; bp_wr_addr = 32'd48; bp_wr_arm = 1'b1;
    id_pc = 32'd48; id_valid = 1'b1; halt_req = 1'b1;
    cyc("wr_old_contents", 1'b1, S_RUN, 2'd0, 2'd0);
    bp_wr_en = 1'b0; halt_req = 1'b0;
    cyc("ext_halt", 1'b1, S_HALT, 2'd3, 2'd0);

    // Step of 3 with a stall, breakpoint and halt_req present but ignored
    step_count = 8'd3; btn_step = 1'b1; halt_req = 1'b1;
    hold(7, "step3_wait", 1'b1, S_HALT, 2'd3, 2'd0);
    id_advance = 1'b1; cyc("step3_adv1", 1'b0, S_STEP, 2'd3, 2'd0);
    id_advance = 1'b0; cyc("step3_stall", 1'b0, S_STEP, 2'd3, 2'd0);
    id_advance = 1'b1; cyc("step3_adv2", 1'b0, S_STEP, 2'd3, 2'd0);
    cyc("step3_adv3", 1'b0, S_STEP, 2'd3, 2'd0);
    id_advance = 1'b0; halt_req = 1'b0; btn_step = 1'b0;
    hold(8, "step3_done", 1'b1, S_HALT, 2'd2, 2'd0);

    // Step count 0 behaves as 1
    step_count = 8'd0; btn_step = 1'b1;
    hold(7, "step0_wait", 1'b1, S_HALT, 2'd2, 2'd0);
    id_advance = 1'b1; cyc("step0_adv1", 1'b0, S_STEP, 2'd2, 2'd0);
    id_advance = 1'b0; btn_step = 1'b0;
    hold(8, "step0_done", 1'b1, S_HALT, 2'd2, 2'd0);

    // Continue and step together -> RESUME; halt_req in RESUME -> HALT cause 3
    btn_continue = 1'b1; btn_step = 1'b1;
    hold(7, "both_wait", 1'b1, S_HALT, 2'd2, 2'd0);
    halt_req = 1'b1; cyc("both_resume", 1'b1, S_RESUME, 2'd2, 2'd0);
    halt_req = 1'b0; btn_continue = 1'b0; btn_step = 1'b0;
    hold(8, "resume_ext_halt", 1'b1, S_HALT, 2'd3, 2'd0);

    // Bounce: toggles every 2 cycles never settle; the final held rise is accepted once
    for (int i = 0; i < 10; i++) begin
      btn_continue = (i % 2 == 0);
      hold(2, "bounce", 1'b1, S_HALT, 2'd3, 2'd0);
    end
    btn_continue = 1'b1;
    hold(7, "bounce_final", 1'b1, S_HALT, 2'd3, 2'd0);
    id_pc = 32'd40; id_advance = 1'b1;
    cyc("bounce_resume", 1'b0, S_RESUME, 2'd3, 2'd0);

    // Breakpoint at 48 beats a simultaneous halt_req
    id_pc = 32'd44; cyc("run_44", 1'b0, S_RUN, 2'd3, 2'd0);
    id_pc = 32'd48; id_advance = 1'b0; halt_req = 1'b1;
    cyc("bp_freeze", 1'b1, S_RUN, 2'd3, 2'd0);
    halt_req = 1'b0; btn_continue = 1'b0;
    hold(8, "bp_halt", 1'b1, S_HALT, 2'd1, 2'd2);

    // Continue with a 3-cycle stall in RESUME: no re-halt at 48
    btn_continue = 1'b1;
    hold(7, "cont_wait", 1'b1, S_HALT, 2'd1, 2'd2);
    hold(3, "resume_stall", 1'b0, S_RESUME, 2'd1, 2'd2);
    id_advance = 1'b1; cyc("resume_issue", 1'b0, S_RESUME, 2'd1, 2'd2);
    id_pc = 32'd52; cyc("run_52", 1'b0, S_RUN, 2'd1, 2'd2);

    // Second slot at 48 (low address bits set) -> lower index reported
    bp_wr_en = 1'b1; bp_wr_idx = 2'd1; bp_wr_addr = 32'd51;
    cyc("wr_slot1", 1'b0, S_RUN, 2'd1, 2'd2);
    bp_wr_en = 1'b0; id_pc = 32'd48; id_advance = 1'b0;
    cyc("dual_freeze", 1'b1, S_RUN, 2'd1, 2'd2);
    cyc("dual_halt", 1'b1, S_HALT, 2'd1, 2'd1);

    // Asynchronous reset in the middle of a 5-instruction step
    step_count = 8'd5; btn_step = 1'b1;
    hold(7, "step5_wait", 1'b1, S_HALT, 2'd1, 2'd1);
    hold(2, "step5_stalled", 1'b0, S_STEP, 2'd1, 2'd1);
    rst_n = 1'b0;
    chk("reset_async", 1'b0, S_RUN, 2'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1; id_advance = 1'b1;
    cyc("post_reset_disarmed", 1'b0, S_RUN, 2'd0, 2'd0);
    cyc("post_reset_run", 1'b0, S_RUN, 2'd0, 2'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
